// File: rtl/ucie_rdi_pkg.sv
// Shared RDI definitions: status encodings, FSM state enum and decode helpers.
package ucie_rdi_pkg;

    // Encodings carried on pl_state_sts / lp_state_req.
    localparam logic [3:0] StsNop       = 4'h0;
    localparam logic [3:0] StsActive    = 4'h1;
    localparam logic [3:0] StsL1        = 4'h4;
    localparam logic [3:0] StsL2        = 4'h8;
    localparam logic [3:0] StsLinkReset = 4'h9;
    localparam logic [3:0] StsLinkError = 4'hA;
    localparam logic [3:0] StsRetrain   = 4'hB;
    localparam logic [3:0] StsDisabled  = 4'hC;

    typedef enum logic [3:0] {
        StReset,
        StActive,
        StStallWait,
        StL1,
        StL2,
        StLinkReset,
        StLinkError,
        StRetrain,
        StDisabled
    } pl_state_e;

    // Status reported for a settled state; the stall handshake still reads as Active.
    function automatic logic [3:0] state_sts(input pl_state_e st);
        logic [3:0] sts;
        sts = StsNop;
        case (st)
            StActive, StStallWait: sts = StsActive;
            StL1:                  sts = StsL1;
            StL2:                  sts = StsL2;
            StLinkReset:           sts = StsLinkReset;
            StLinkError:           sts = StsLinkError;
            StRetrain:             sts = StsRetrain;
            StDisabled:            sts = StsDisabled;
            default:               sts = StsNop;
        endcase
        return sts;
    endfunction

    // Requests that must go through the stall handshake when seen in Active.
    function automatic logic is_stall_target(input logic [3:0] req);
        return (req == StsL1) || (req == StsL2) || (req == StsLinkReset) ||
               (req == StsDisabled);
    endfunction

    function automatic pl_state_e req_to_state(input logic [3:0] req);
        pl_state_e st;
        st = StReset;
        case (req)
            StsL1:        st = StL1;
            StsL2:        st = StL2;
            StsLinkReset: st = StLinkReset;
            StsDisabled:  st = StDisabled;
            default:      st = StReset;
        endcase
        return st;
    endfunction

    // States in which the adapter clock may be gated.
    function automatic logic is_clk_gated(input pl_state_e st);
        return (st == StL1) || (st == StL2) || (st == StDisabled);
    endfunction

endpackage

// File: rtl/ucie_rdi_timer.sv
// Residency / timeout counter: cleared by load, counts while enabled, saturates at expiry.
module ucie_rdi_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] limit_i,
    output logic             expire_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Expires on the limit-th enabled cycle after load; a zero limit expires at once.
    assign expire_o = ({1'b0, count_q} + {{Width{1'b0}}, 1'b1}) >= {1'b0, limit_i};

    // Next count: load clears, enable advances until expiry.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && !expire_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ucie_rdi_pl_state_ctrl.sv
// Physical-layer side RDI state controller: stall handshake, low-power clock
// handshake, retrain residency and error escalation. All outputs are registered.
module ucie_rdi_pl_state_ctrl
    import ucie_rdi_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT  = 1024,
    parameter int unsigned RETRAIN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lt_link_up,
    input  logic       lt_error,
    input  logic       lt_retrain_req,
    input  logic [3:0] lp_state_req,
    input  logic       lp_stallack,
    input  logic       lp_wake_req,
    input  logic       lp_clk_ack,
    output logic [3:0] pl_state_sts,
    output logic       pl_stallreq,
    output logic       pl_wake_ack,
    output logic       pl_clk_req,
    output logic       pl_tx_ready,
    output logic       link_up,
    output logic       link_error,
    output logic [7:0] link_status
);

    localparam logic [15:0] StallLimit   = 16'(STALL_TIMEOUT);
    localparam logic [15:0] RetrainLimit = 16'(RETRAIN_CYCLES);

    pl_state_e   state_q, state_d;
    pl_state_e   tgt_q, tgt_d;     // destination once the stall handshake completes
    pl_state_e   exit_q, exit_d;   // destination once the clock is acknowledged
    logic        clk_pend_q, clk_pend_d;
    logic        wake_ack_q;
    logic [3:0]  sts_q, sts_d;
    logic        stallreq_q, stallreq_d;
    logic        clk_req_q, clk_req_d;
    logic        tx_ready_q, tx_ready_d;
    logic        link_up_q;
    logic        link_error_q, link_error_d;

    logic        tmr_load;
    logic        tmr_en;
    logic [15:0] tmr_limit;
    logic        tmr_expire;

    assign tmr_en    = (state_q == StStallWait) || (state_q == StRetrain);
    assign tmr_limit = (state_q == StStallWait) ? StallLimit : RetrainLimit;

    ucie_rdi_timer #(
        .Width (16)
    ) u_timer (
        .clk_i    (clk),
        .resetn_i (resetn),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .limit_i  (tmr_limit),
        .expire_o (tmr_expire)
    );

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        exit_d     = exit_q;
        clk_pend_d = clk_pend_q;

        if (lt_error) begin
            state_d    = StLinkError;
            clk_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                StReset: begin
                    if ((lp_state_req == StsActive) && lt_link_up && wake_ack_q) begin
                        state_d = StActive;
                    end
                end
                StActive: begin
                    // Adapter requests take priority over a PHY retrain in the same cycle.
                    if (is_stall_target(lp_state_req)) begin
                        tgt_d   = req_to_state(lp_state_req);
                        state_d = StStallWait;
                    end else if (lt_retrain_req) begin
                        tgt_d   = StRetrain;
                        state_d = StStallWait;
                    end
                end
                StStallWait: begin
                    if (lp_stallack) begin
                        state_d = tgt_q;
                    end else if (tmr_expire) begin
                        state_d = StLinkError;
                    end
                end
                StL1, StL2, StDisabled: begin
                    // Raise the clock request first, leave only after the ack is seen.
                    if (clk_pend_q) begin
                        if (lp_clk_ack) begin
                            state_d    = exit_q;
                            clk_pend_d = 1'b0;
                        end
                    end else if (lp_state_req == StsActive) begin
                        clk_pend_d = 1'b1;
                        exit_d     = (state_q == StL1) ? StRetrain : StReset;
                    end
                end
                StLinkReset, StLinkError: begin
                    if (lp_state_req == StsActive) begin
                        state_d = StReset;
                    end
                end
                StRetrain: begin
                    if (tmr_expire && lt_link_up) begin
                        state_d = StActive;
                    end
                end
                default: state_d = StReset;
            endcase
        end

        tmr_load = (state_d != state_q) &&
                   ((state_d == StStallWait) || (state_d == StRetrain));

        sts_d        = state_sts(state_d);
        stallreq_d   = (state_d == StStallWait);
        clk_req_d    = !is_clk_gated(state_d) || clk_pend_d;
        tx_ready_d   = (state_d == StActive);
        link_error_d = (state_d == StLinkError);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StReset;
            tgt_q        <= StReset;
            exit_q       <= StReset;
            clk_pend_q   <= 1'b0;
            wake_ack_q   <= 1'b0;
            sts_q        <= StsNop;
            stallreq_q   <= 1'b0;
            clk_req_q    <= 1'b1;
            tx_ready_q   <= 1'b0;
            link_up_q    <= 1'b0;
            link_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            exit_q       <= exit_d;
            clk_pend_q   <= clk_pend_d;
            wake_ack_q   <= lp_wake_req;
            sts_q        <= sts_d;
            stallreq_q   <= stallreq_d;
            clk_req_q    <= clk_req_d;
            tx_ready_q   <= tx_ready_d;
            link_up_q    <= tx_ready_d;
            link_error_q <= link_error_d;
        end
    end

    assign pl_state_sts = sts_q;
    assign pl_stallreq  = stallreq_q;
    assign pl_wake_ack  = wake_ack_q;
    assign pl_clk_req   = clk_req_q;
    assign pl_tx_ready  = tx_ready_q;
    assign link_up      = link_up_q;
    assign link_error   = link_error_q;
    // pend and stall both track the stall handshake.
    assign link_status  = {stallreq_q, stallreq_q, 2'b00, sts_q};

endmodule

// File: tb/tb_ucie_rdi_pl_state_ctrl.sv
// Bench for ucie_rdi_pl_state_ctrl: directed vector table and hand sequences,
// then randomized traffic checked against a status-level reference model.
module tb_ucie_rdi_pl_state_ctrl;

    localparam int Timeout = 8;
    localparam int Retrain = 16;

    logic       clk;
    logic       resetn;
    logic       lt_link_up;
    logic       lt_error;
    logic       lt_retrain_req;
    logic [3:0] lp_state_req;
    logic       lp_stallack;
    logic       lp_wake_req;
    logic       lp_clk_ack;
    logic [3:0] pl_state_sts;
    logic       pl_stallreq;
    logic       pl_wake_ack;
    logic       pl_clk_req;
    logic       pl_tx_ready;
    logic       link_up;
    logic       link_error;
    logic [7:0] link_status;

    int n_checks = 0;
    int n_pass   = 0;

    ucie_rdi_pl_state_ctrl #(
        .STALL_TIMEOUT  (Timeout),
        .RETRAIN_CYCLES (Retrain)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .lt_link_up     (lt_link_up),
        .lt_error       (lt_error),
        .lt_retrain_req (lt_retrain_req),
        .lp_state_req   (lp_state_req),
        .lp_stallack    (lp_stallack),
        .lp_wake_req    (lp_wake_req),
        .lp_clk_ack     (lp_clk_ack),
        .pl_state_sts   (pl_state_sts),
        .pl_stallreq    (pl_stallreq),
        .pl_wake_ack    (pl_wake_ack),
        .pl_clk_req     (pl_clk_req),
        .pl_tx_ready    (pl_tx_ready),
        .link_up        (link_up),
        .link_error     (link_error),
        .link_status    (link_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rstn, lu, err, rt;
        logic [3:0] req;
        logic       ack, wake, cack;
        logic [3:0] sts;
        logic       sreq, wack, creq, tx, le;
    } vec_t;

    // Reference model, tracked as reported status codes plus handshake flags.
    logic [3:0] m_sts, m_tgt, m_exit;
    logic       m_stall, m_clkwait, m_wake;
    int         m_cnt, m_rt;

    task automatic model_step();
        logic old_wake;
        if (!resetn) begin
            m_sts = 4'h0; m_tgt = 4'h0; m_exit = 4'h0;
            m_stall = 1'b0; m_clkwait = 1'b0; m_wake = 1'b0;
            m_cnt = 0; m_rt = 0;
            return;
        end
        old_wake = m_wake;
        m_wake   = lp_wake_req;
        if (lt_error) begin
            m_sts = 4'hA; m_stall = 1'b0; m_clkwait = 1'b0;
        end else if (m_stall) begin
            if (lp_stallack) begin
                m_stall = 1'b0; m_sts = m_tgt; m_rt = 0;
            end else begin
                m_cnt++;
                if (m_cnt >= Timeout) begin
                    m_stall = 1'b0; m_sts = 4'hA;
                end
            end
        end else begin
            case (m_sts)
                4'h0: if (lp_state_req == 4'h1 && lt_link_up && old_wake) m_sts = 4'h1;
                4'h1: begin
                    if (lp_state_req inside {4'h4, 4'h8, 4'h9, 4'hC}) begin
                        m_stall = 1'b1; m_tgt = lp_state_req; m_cnt = 0;
                    end else if (lt_retrain_req) begin
                        m_stall = 1'b1; m_tgt = 4'hB; m_cnt = 0;
                    end
                end
                4'h4, 4'h8, 4'hC: begin
                    if (m_clkwait) begin
                        if (lp_clk_ack) begin
                            m_sts = m_exit; m_clkwait = 1'b0; m_rt = 0;
                        end
                    end else if (lp_state_req == 4'h1) begin
                        m_clkwait = 1'b1;
                        m_exit    = (m_sts == 4'h4) ? 4'hB : 4'h0;
                    end
                end
                4'h9, 4'hA: if (lp_state_req == 4'h1) m_sts = 4'h0;
                4'hB: begin
                    m_rt++;
                    if (m_rt >= Retrain && lt_link_up) m_sts = 4'h1;
                end
                default: m_sts = 4'h0;
            endcase
        end
    endtask

    function automatic logic [17:0] pack(input logic [3:0] sts, input logic sreq, wack,
                                         creq, tx, le);
        return {sts, sreq, wack, creq, tx, tx, le, sreq, sreq, 2'b00, sts};
    endfunction

    function automatic logic [17:0] dut_out();
        return {pl_state_sts, pl_stallreq, pl_wake_ack, pl_clk_req, pl_tx_ready, link_up,
                link_error, link_status};
    endfunction

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = dut_out();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rstn, lu, err, rt, input logic [3:0] req,
                         input logic ack, wake, cack);
        resetn = rstn; lt_link_up = lu; lt_error = err; lt_retrain_req = rt;
        lp_state_req = req; lp_stallack = ack; lp_wake_req = wake; lp_clk_ack = cack;
    endtask

    // Apply one vector across a rising edge and compare at the falling edge.
    task automatic run_vec(input vec_t v);
        drive(v.rstn, v.lu, v.err, v.rt, v.req, v.ack, v.wake, v.cack);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(v.name, pack(v.sts, v.sreq, v.wack, v.creq, v.tx, v.le));
    endtask

    function automatic vec_t mk(input string name, input logic rstn, lu, err, rt,
                                input logic [3:0] req, input logic ack, wake, cack,
                                input logic [3:0] sts, input logic sreq, wack, creq, tx, le);
        vec_t v;
        v.name = name; v.rstn = rstn; v.lu = lu; v.err = err; v.rt = rt; v.req = req;
        v.ack = ack; v.wake = wake; v.cack = cack; v.sts = sts; v.sreq = sreq;
        v.wack = wack; v.creq = creq; v.tx = tx; v.le = le;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        //            name         rst lu er rt req  ak wk ca   sts  sr wa cr tx le
        tbl.push_back(mk("reset",    0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("wake_ack", 1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("to_act",   1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h1, 0, 1, 1, 1, 0));
        tbl.push_back(mk("act_hold", 1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h1, 0, 1, 1, 1, 0));
        tbl.push_back(mk("req_l1",   1, 1, 0, 0, 4'h4, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        tbl.push_back(mk("stall1",   1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        tbl.push_back(mk("stall2",   1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        tbl.push_back(mk("stallack", 1, 1, 0, 0, 4'h0, 1, 1, 0, 4'h4, 0, 1, 0, 0, 0));
        tbl.push_back(mk("l1_hold",  1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h4, 0, 1, 0, 0, 0));
        tbl.push_back(mk("l1_exit",  1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h4, 0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("clk_wait", 1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h4, 0, 1, 1, 0, 0));
        tbl.push_back(mk("clk_ack",  1, 1, 0, 0, 4'h0, 0, 1, 1, 4'hB, 0, 1, 1, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Retrain residency: no exit before 16 cycles, and none without link up.
        for (int i = 1; i < Retrain; i++)
            run_vec(mk("rt_resid", 1, 1, 0, 0, 4'h0, 0, 1, 0, 4'hB, 0, 1, 1, 0, 0));
        run_vec(mk("rt_no_lu",  1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hB, 0, 1, 1, 0, 0));
        run_vec(mk("rt_exit",   1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h1, 0, 1, 1, 1, 0));

        // Stall timeout escalates to LinkError after exactly Timeout cycles.
        run_vec(mk("req_l2",    1, 1, 0, 0, 4'h8, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        for (int i = 1; i < Timeout; i++)
            run_vec(mk("to_wait", 1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        run_vec(mk("timeout",   1, 1, 0, 0, 4'h0, 0, 1, 0, 4'hA, 0, 1, 1, 0, 1));
        run_vec(mk("err_hold",  1, 1, 0, 0, 4'h0, 0, 1, 0, 4'hA, 0, 1, 1, 0, 1));
        run_vec(mk("err_exit",  1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0));
        run_vec(mk("react",     1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h1, 0, 1, 1, 1, 0));

        // lt_error beats a simultaneous stall acknowledge.
        run_vec(mk("req_lr",    1, 1, 0, 0, 4'h9, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        run_vec(mk("err_win",   1, 1, 1, 0, 4'h0, 1, 1, 0, 4'hA, 0, 1, 1, 0, 1));
        run_vec(mk("err_stick", 1, 1, 1, 0, 4'h1, 0, 1, 0, 4'hA, 0, 1, 1, 0, 1));
        run_vec(mk("err_clr",   1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0));
        run_vec(mk("react2",    1, 1, 0, 0, 4'h1, 0, 1, 0, 4'h1, 0, 1, 1, 1, 0));

        // Reset in the middle of a stall handshake.
        run_vec(mk("req_dis",   1, 1, 0, 0, 4'hC, 0, 1, 0, 4'h1, 1, 1, 1, 0, 0));
        run_vec(mk("rst_stall", 0, 1, 0, 0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 1, 0, 0));
        run_vec(mk("post_rst",  1, 1, 0, 0, 4'h0, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0));

        // Randomized traffic against the reference model.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] req;
            case ($urandom_range(0, 7))
                0, 1:    req = 4'h1;
                2:       req = 4'h4;
                3:       req = 4'h8;
                4:       req = 4'h9;
                5:       req = 4'hC;
                6:       req = 4'h0;
                default: req = 4'($urandom_range(0, 15));
            endcase
            if (i > 0) begin
                drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0), req,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 2) == 0));
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("random", pack(m_sts, m_stall, m_wake,
                                 !(m_sts inside {4'h4, 4'h8, 4'hC}) || m_clkwait,
                                 (m_sts == 4'h1) && !m_stall, m_sts == 4'hA));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
